// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for the shared 8-bit/12-bit memory port: picks a requester, sequences one access, drives mux selects.
// Latency: grant one edge after req is seen in IDLE, ack MEM_LAT cycles later; requests are ignored (held off) while busy.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter bit RR      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] we,
    output logic       sel_first,
    output logic       sel_second,
    output logic       sel_third,
    output logic       mem_en,
    output logic       mem_we,
    output logic [2:0] ack,
    output logic [1:0] grant_id,
    output logic       busy
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] sel_q, sel_d;
    logic       mem_en_q, mem_en_d;
    logic       mem_we_q, mem_we_d;
    logic [2:0] ack_q, ack_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic       busy_q, busy_d;
    logic [1:0] last_grant_q, last_grant_d;
    logic [1:0] winner;
    logic [2:0] winner_oh;

    // Round-robin scans last+1, last+2, last+3 (mod 3); the loop runs
    // backwards so the earliest hit in scan order overwrites the rest.
    function automatic logic [1:0] pick_winner(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] w;
        logic [1:0] idx;
        w = 2'd0;
        if (RR) begin
            for (int k = 3; k >= 1; k--) begin
                idx = 2'((int'(last) + k) % 3);
                if (r[idx]) w = idx;
            end
        end else begin
            if (r[2]) w = 2'd2;
            if (r[1]) w = 2'd1;
            if (r[0]) w = 2'd0;
        end
        return w;
    endfunction

    always_comb begin
        winner       = pick_winner(req, last_grant_q);
        winner_oh    = 3'b001 << winner;
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = 1'b0;
        ack_d        = 3'b000;
        grant_id_d   = grant_id_q;
        busy_d       = busy_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d      = ACCESS;
                    cnt_d        = 4'd0;
                    sel_d        = winner_oh;
                    mem_en_d     = 1'b1;
                    mem_we_d     = we[winner];
                    busy_d       = 1'b1;
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    ack_d        = (LAST_CNT == 4'd0) ? winner_oh : 3'b000;
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d    = IDLE;
                    cnt_d      = 4'd0;
                    sel_d      = 3'b000;
                    mem_en_d   = 1'b0;
                    grant_id_d = 2'd3;
                    busy_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    // Ack is registered, so it is launched one edge ahead of the final cycle.
                    ack_d = (cnt_q + 4'd1 == LAST_CNT) ? sel_q : 3'b000;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            sel_q        <= 3'b000;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            ack_q        <= 3'b000;
            grant_id_q   <= 2'd3;
            busy_q       <= 1'b0;
            last_grant_q <= 2'd2;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            ack_q        <= ack_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign sel_first  = sel_q[0];
    assign sel_second = sel_q[1];
    assign sel_third  = sel_q[2];
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign ack        = ack_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three configurations (RR/lat2, fixed/lat3, RR/lat1) checked every cycle
// against a schedule model that queues the expected output words of each granted access.
module tb_mem_port_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] req [3];
    logic [2:0] we  [3];
    logic       sf  [3];
    logic       ss  [3];
    logic       st  [3];
    logic       men [3];
    logic       mwe [3];
    logic [2:0] ackv[3];
    logic [1:0] gid [3];
    logic       bsy [3];
    logic [10:0] obs[3];

    mem_port_arbiter #(.MEM_LAT(2), .RR(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]),
        .sel_first(sf[0]), .sel_second(ss[0]), .sel_third(st[0]),
        .mem_en(men[0]), .mem_we(mwe[0]), .ack(ackv[0]), .grant_id(gid[0]), .busy(bsy[0]));

    mem_port_arbiter #(.MEM_LAT(3), .RR(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]),
        .sel_first(sf[1]), .sel_second(ss[1]), .sel_third(st[1]),
        .mem_en(men[1]), .mem_we(mwe[1]), .ack(ackv[1]), .grant_id(gid[1]), .busy(bsy[1]));

    mem_port_arbiter #(.MEM_LAT(1), .RR(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req[2]), .we(we[2]),
        .sel_first(sf[2]), .sel_second(ss[2]), .sel_third(st[2]),
        .mem_en(men[2]), .mem_we(mwe[2]), .ack(ackv[2]), .grant_id(gid[2]), .busy(bsy[2]));

    // Observed word: {sel[2:0], mem_en, mem_we, ack[2:0], grant_id, busy}
    assign obs[0] = {st[0], ss[0], sf[0], men[0], mwe[0], ackv[0], gid[0], bsy[0]};
    assign obs[1] = {st[1], ss[1], sf[1], men[1], mwe[1], ackv[1], gid[1], bsy[1]};
    assign obs[2] = {st[2], ss[2], sf[2], men[2], mwe[2], ackv[2], gid[2], bsy[2]};

    localparam logic [10:0] IDLE_V = 11'b000_0_0_000_11_0;

    int          lat [3];
    bit          rr  [3];
    logic [10:0] sched[3][16];
    int          depth[3];
    logic [1:0]  last[3];
    bit          cur_idle[3];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] l, input bit rr_mode);
        if (!rr_mode) begin
            for (int i = 0; i < 3; i++) if (r[i]) return 2'(i);
        end else begin
            for (int k = 1; k <= 3; k++) begin
                int i;
                i = (int'(l) + k) % 3;
                if (r[i]) return 2'(i);
            end
        end
        return 2'd3;
    endfunction

    task automatic compare(input int i, input logic [10:0] e, input string tag);
        checks++;
        assert (obs[i] === e)
        else begin
            errors++;
            $error("FAIL %s dut%0d observed=%b expected=%b", tag, i, obs[i], e);
        end
    endtask

    task automatic check(input int i, input string tag);
        logic [10:0] e;
        if (depth[i] > 0) begin
            e = sched[i][0];
            for (int k = 0; k < 15; k++) sched[i][k] = sched[i][k+1];
            depth[i]--;
        end else begin
            e = IDLE_V;
        end
        cur_idle[i] = !e[0];
        compare(i, e, tag);
    endtask

    // A request seen while the port is idle becomes a lat-cycle access starting next cycle.
    task automatic plan(input int i);
        logic [1:0] w;
        logic [2:0] oh;
        if (cur_idle[i] && (|req[i])) begin
            w = pick(req[i], last[i], rr[i]);
            last[i] = w;
            oh = 3'b001 << w;
            for (int k = 0; k < lat[i]; k++)
                sched[i][k] = {oh, 1'b1, (k == 0) & we[i][w], (k == lat[i]-1) ? oh : 3'b000, w, 1'b1};
            depth[i] = lat[i];
        end
    endtask

    task automatic sample(input string tag);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check(i, tag);
    endtask

    task automatic commit();
        for (int i = 0; i < 3; i++) plan(i);
    endtask

    task automatic step(input logic [2:0] r, input logic [2:0] w, input string tag);
        sample(tag);
        for (int i = 0; i < 3; i++) begin
            req[i] = r;
            we[i]  = w;
        end
        commit();
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(3'b000, 3'b000, "idle");
    endtask

    // Reset lands mid-cycle; outputs must clear before any further clock edge.
    task automatic do_reset(input logic [2:0] r, input string tag);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            depth[i] = 0;
            last[i]  = 2'd2;
            compare(i, IDLE_V, tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cur_idle[i] = 1'b1;
            req[i] = r;
            we[i]  = 3'b000;
        end
        commit();
    endtask

    initial begin
        lat[0] = 2; rr[0] = 1'b1;
        lat[1] = 3; rr[1] = 1'b0;
        lat[2] = 1; rr[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 3'b000;
            we[i]  = 3'b000;
            depth[i] = 0;
            last[i] = 2'd2;
            cur_idle[i] = 1'b1;
        end

        do_reset(3'b000, "reset");
        drain(2);

        step(3'b001, 3'b000, "single_read");
        drain(4);

        for (int k = 0; k < 12; k++) step(3'b111, 3'b000, "rr_all_held");
        drain(4);

        for (int k = 0; k < 12; k++) step(3'b011, 3'b000, "fixed_prio");
        drain(4);

        step(3'b010, 3'b010, "single_write");
        drain(4);

        step(3'b100, 3'b100, "write_req2");
        step(3'b100, 3'b000, "read_req2");
        drain(4);

        step(3'b010, 3'b000, "grant_req1");
        do_reset(3'b111, "reset_mid_access");
        for (int k = 0; k < 8; k++) step(3'b111, 3'b000, "after_reset");
        drain(4);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset(3'($urandom_range(0, 7)), "rand_reset");
            end else begin
                sample("random");
                for (int i = 0; i < 3; i++) begin
                    req[i] = 3'($urandom_range(0, 7));
                    we[i]  = 3'($urandom_range(0, 7));
                end
                commit();
            end
        end
        drain(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
